// File: rtl/pattern_serial_tx.sv
// Serial pattern transmitter: shifts a DATA_W-bit word out MSB-first, repeated back-to-back.
// Optional macro PATTERN_TX_PARITY_EN appends an even-parity bit after every repetition.
module pattern_serial_tx #(
    parameter int DATA_W     = 5,
    parameter int REP_W      = 4,
    parameter int GAP_CYCLES = 1
) (
    input  logic              clk,
    input  logic              reset_n,
    input  logic              in_valid,
    output logic              in_ready,
    input  logic [DATA_W-1:0] in_data,
    input  logic [REP_W-1:0]  in_repeat,
    output logic              x,
    output logic              x_valid,
    output logic              busy,
    output logic              done
);

`ifdef PATTERN_TX_PARITY_EN
    localparam int LAST = DATA_W;      // data bits plus one parity slot
`else
    localparam int LAST = DATA_W - 1;
`endif
    localparam int BIT_W = $clog2(LAST + 1);
    localparam int GAP_W = (GAP_CYCLES > 1) ? $clog2(GAP_CYCLES) : 1;

    typedef enum logic [1:0] {IDLE, SHIFT, GAP} state_t;

    state_t            state, state_nxt;
    logic [DATA_W-1:0] pattern, pattern_nxt;
    logic [DATA_W-1:0] shift_reg, shift_nxt;
    logic [REP_W-1:0]  rep_cnt, rep_nxt;
    logic [BIT_W-1:0]  bit_cnt, bit_nxt;
    logic [GAP_W-1:0]  gap_cnt, gap_nxt;
    logic              x_nxt, x_valid_nxt, done_nxt, in_ready_nxt;

    assign busy = (state != IDLE);

    // NOTE: every signal gets a default first so no path leaves one unassigned (no latches).
    always_comb begin
        state_nxt    = state;
        pattern_nxt  = pattern;
        shift_nxt    = shift_reg;
        rep_nxt      = rep_cnt;
        bit_nxt      = bit_cnt;
        gap_nxt      = gap_cnt;
        x_nxt        = 1'b0;
        x_valid_nxt  = 1'b0;
        done_nxt     = 1'b0;
        in_ready_nxt = 1'b0;

        case (state)
            IDLE: begin
                if (in_valid && in_ready) begin
                    pattern_nxt = in_data;
                    shift_nxt   = in_data;
                    rep_nxt     = (in_repeat == '0) ? REP_W'(1) : in_repeat;
                    bit_nxt     = BIT_W'(LAST);
                    x_nxt       = in_data[DATA_W-1];
                    x_valid_nxt = 1'b1;
                    state_nxt   = SHIFT;
                end else begin
                    in_ready_nxt = 1'b1;
                end
            end
            SHIFT: begin
                if (bit_cnt != '0) begin
`ifdef PATTERN_TX_PARITY_EN
                    x_nxt = (bit_cnt == BIT_W'(1)) ? ^pattern : shift_reg[DATA_W-2];
`else
                    x_nxt = shift_reg[DATA_W-2];
`endif
                    x_valid_nxt = 1'b1;
                    shift_nxt   = shift_reg << 1;
                    bit_nxt     = bit_cnt - BIT_W'(1);
                    done_nxt    = (bit_cnt == BIT_W'(1)) && (rep_cnt == REP_W'(1));
                end else if (rep_cnt > REP_W'(1)) begin
                    // Gapless reload so detectors see overlapping occurrences.
                    shift_nxt   = pattern;
                    x_nxt       = pattern[DATA_W-1];
                    x_valid_nxt = 1'b1;
                    rep_nxt     = rep_cnt - REP_W'(1);
                    bit_nxt     = BIT_W'(LAST);
                end else if (GAP_CYCLES > 0) begin
                    gap_nxt   = GAP_W'((GAP_CYCLES > 0) ? GAP_CYCLES - 1 : 0);
                    state_nxt = GAP;
                end else begin
                    in_ready_nxt = 1'b1;
                    state_nxt    = IDLE;
                end
            end
            GAP: begin
                if (gap_cnt == '0) begin
                    in_ready_nxt = 1'b1;
                    state_nxt    = IDLE;
                end else begin
                    gap_nxt = gap_cnt - GAP_W'(1);
                end
            end
            default: state_nxt = IDLE;
        endcase
    end

    // NOTE: sequential state uses non-blocking assignments only.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state     <= IDLE;
            pattern   <= '0;
            shift_reg <= '0;
            rep_cnt   <= '0;
            bit_cnt   <= '0;
            gap_cnt   <= '0;
            x         <= 1'b0;
            x_valid   <= 1'b0;
            done      <= 1'b0;
            in_ready  <= 1'b0;
        end else begin
            state     <= state_nxt;
            pattern   <= pattern_nxt;
            shift_reg <= shift_nxt;
            rep_cnt   <= rep_nxt;
            bit_cnt   <= bit_nxt;
            gap_cnt   <= gap_nxt;
            x         <= x_nxt;
            x_valid   <= x_valid_nxt;
            done      <= done_nxt;
            in_ready  <= in_ready_nxt;
        end
    end

endmodule

// File: doc/pattern_serial_tx.md
Name: pattern_serial_tx

Overview:
- Serial pattern transmitter. Accepts a DATA_W-bit pattern word plus a repeat count over a valid/ready handshake.
- Shifts the word out MSB-first on a 1-bit serial line, with a qualifying valid strobe.
- Drives the x input of the team's sequence detectors. Used as the stimulus and traffic source for detector-based links, e.g. DATA_W=5, word 5'b10110.

Parameters:
DATA_W, 5, pattern width in bits (>=2)
REP_W, 4, width of the repeat-count field
GAP_CYCLES, 1, extra idle cycles after a burst before the next word is accepted (>=0)

Ports:
clk  input  1  system clock, rising edge
reset_n  input  1  reset; one clock; reset is asynchronous and active-low
in_valid  input  1  word offered
in_ready  output  1  block can accept a word this cycle
in_data  input  DATA_W  pattern; bit DATA_W-1 is sent first
in_repeat  input  REP_W  number of back-to-back repetitions; 0 is treated as 1
x  output  1  serial data
x_valid  output  1  x carries a pattern bit this cycle
busy  output  1  burst or gap in progress (state != IDLE)
done  output  1  one-cycle pulse coincident with the final bit of a burst

Behaviour:
- Reset (async assert, sync release): state=IDLE; x=0, x_valid=0, done=0, in_ready=0, busy=0; all counters 0. in_ready rises on the first clk edge after reset_n deasserts.
- All outputs are registered. busy decodes the state register.
- FSM states: IDLE, SHIFT, GAP.
- IDLE:
  - in_ready=1.
  - Accept on the edge where in_valid && in_ready. At that edge: latch in_data into a pattern reg and a shift reg; rep_cnt = max(in_repeat,1); bit_cnt = DATA_W-1.
  - Also at that edge: x <= in_data[DATA_W-1], x_valid <= 1, in_ready <= 0, go to SHIFT.
  - Latency: the first bit is on x in the cycle after the accept edge.
- SHIFT, at each edge:
  - bit_cnt>0: emit the next lower bit; bit_cnt--.
  - bit_cnt==0 and rep_cnt>1: reload the pattern and emit its MSB; rep_cnt--; bit_cnt=DATA_W-1. Repetitions are gapless, so overlapping detection is exercised.
  - bit_cnt==0 and rep_cnt==1: x<=0, x_valid<=0. Go to GAP (gap_cnt=GAP_CYCLES-1) if GAP_CYCLES>0, else go to IDLE with in_ready<=1.
- done=1 in exactly the cycle the final bit of the final repetition is on x; 0 otherwise.
- GAP:
  - x=0, x_valid=0.
  - Count down gap_cnt; on 0, go to IDLE and set in_ready<=1.
  - Between bursts, x_valid is low for at least GAP_CYCLES+1 cycles.
- in_valid/in_data/in_repeat are ignored outside IDLE. Changing them mid-burst has no effect on x.
- Total x_valid-high cycles per burst = DATA_W * max(in_repeat,1), contiguous.
- x is forced to 0 whenever x_valid=0.
- Reset mid-burst: outputs clear immediately; the burst is discarded and not resumed.

Optional Feature:
- Macro PATTERN_TX_PARITY_EN.
- Defined:
  - One even-parity bit (XOR of the DATA_W pattern bits) is appended after every repetition, with x_valid high. Each repetition is DATA_W+1 bits.
  - done coincides with the final repetition's parity bit.
- Undefined: no parity bit, no parity logic synthesized; behaviour exactly as above.

Test Plan:
- DATA_W=5, GAP_CYCLES=1, accept 5'b10110 with repeat=1 at edge E0 -> cycles C1..C5: x=1,0,1,1,0 with x_valid=1; done=1 only in C5; x_valid=0 in C6,C7; in_ready=1 from C7.
- Repeat=3, data 10110 -> 15 contiguous valid bits 101101011010110; done once, on bit 15; busy high C1..C16.
- Repeat=0, data 10011 -> identical to repeat=1 (5 bits, one done).
- Hold in_valid=1 and toggle in_data every cycle during a burst -> only the first word is accepted; output bits unchanged; next word is accepted only when in_ready=1.
- Assert reset_n=0 during bit 3 -> x, x_valid, done, in_ready go 0 asynchronously. After release: in_ready=1 one edge later; no residual bits.
- With PATTERN_TX_PARITY_EN, data 10110, repeat=2 -> 101101101101; done on the 12th bit.
